// File: rtl/tlu_record_reader.sv
// Assembles 8-word TLU records into trigger ID, timestamp and LE fields, and flags sequence and timestamp breaks.
// A record is output one cycle after its last word. While the output is stalled, one record waits and FIFO_READ stays low.
module tlu_record_reader #(
    parameter int CHECK_SEQ = 1,
    parameter int CHECK_TS  = 1
) (
    input  logic        BUS_CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        CLEAR,
    output logic        FIFO_READ,
    input  logic        FIFO_EMPTY,
    input  logic [15:0] FIFO_DATA,
    output logic        REC_VALID,
    input  logic        REC_READY,
    output logic [31:0] REC_TRIG_ID,
    output logic [63:0] REC_TIME_STAMP,
    output logic [31:0] REC_LE,
    output logic        REC_SEQ_ERR,
    output logic        REC_TS_ERR,
    output logic [31:0] REC_CNT,
    output logic [7:0]  SEQ_ERR_CNT,
    output logic [7:0]  TS_ERR_CNT
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_PEND} state_t;

    state_t          state_q, state_d;
    logic [2:0]      wcnt_q, wcnt_d;
    logic            rd, xfer;
    logic [7:0][15:0] asm_q;
    logic [127:0]    rec_w;
    logic            first_q, first_eff, seq_err_w, ts_err_w;
    logic [31:0]     prev_trig_q;
    logic [63:0]     prev_ts_q;
    logic            rec_valid_q, seq_err_q, ts_err_q;
    logic [31:0]     trig_q, le_q, rec_cnt_q;
    logic [63:0]     ts_q;
    logic [7:0]      seq_cnt_q, ts_cnt_q;

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            wcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // A record only starts from IDLE, so once started it reads out all 8 words regardless of ENABLE.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rd      = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!FIFO_EMPTY && ENABLE) begin
                    rd      = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd = 1'b1;
                if (wcnt_q == 3'd7) state_d = S_PEND;
            end
            S_PEND: begin
                if (!rec_valid_q || REC_READY) begin
                    xfer    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rd) wcnt_d = wcnt_q + 3'd1;
    end

    assign FIFO_READ = rd & ~RST;

    always_ff @(posedge BUS_CLK) begin
        if (FIFO_READ) asm_q[wcnt_q] <= FIFO_DATA;
    end

    assign rec_w     = asm_q;
    // A CLEAR in the same cycle as a transfer makes that record the new reference.
    assign first_eff = first_q | CLEAR;
    assign seq_err_w = (CHECK_SEQ != 0) && !first_eff && (rec_w[127:96] != prev_trig_q + 32'd1);
    assign ts_err_w  = (CHECK_TS != 0) && !first_eff && (rec_w[95:32] <= prev_ts_q);

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            rec_valid_q <= 1'b0;
            trig_q      <= 32'd0;
            ts_q        <= 64'd0;
            le_q        <= 32'd0;
            seq_err_q   <= 1'b0;
            ts_err_q    <= 1'b0;
            prev_trig_q <= 32'd0;
            prev_ts_q   <= 64'd0;
            first_q     <= 1'b1;
            rec_cnt_q   <= 32'd0;
            seq_cnt_q   <= 8'd0;
            ts_cnt_q    <= 8'd0;
        end else begin
            rec_valid_q <= xfer | (rec_valid_q & ~REC_READY);
            if (xfer) begin
                trig_q      <= rec_w[127:96];
                ts_q        <= rec_w[95:32];
                le_q        <= rec_w[31:0];
                seq_err_q   <= seq_err_w;
                ts_err_q    <= ts_err_w;
                prev_trig_q <= rec_w[127:96];
                prev_ts_q   <= rec_w[95:32];
                first_q     <= 1'b0;
            end else if (CLEAR) begin
                first_q <= 1'b1;
            end
            if (CLEAR) begin
                rec_cnt_q <= 32'd0;
                seq_cnt_q <= 8'd0;
                ts_cnt_q  <= 8'd0;
            end else if (xfer) begin
                rec_cnt_q <= rec_cnt_q + 32'd1;
                if (seq_err_w && seq_cnt_q != 8'hFF) seq_cnt_q <= seq_cnt_q + 8'd1;
                if (ts_err_w && ts_cnt_q != 8'hFF) ts_cnt_q <= ts_cnt_q + 8'd1;
            end
        end
    end

    assign REC_VALID      = rec_valid_q;
    assign REC_TRIG_ID    = trig_q;
    assign REC_TIME_STAMP = ts_q;
    assign REC_LE         = le_q;
    assign REC_SEQ_ERR    = seq_err_q;
    assign REC_TS_ERR     = ts_err_q;
    assign REC_CNT        = rec_cnt_q;
    assign SEQ_ERR_CNT    = seq_cnt_q;
    assign TS_ERR_CNT     = ts_cnt_q;
endmodule

// File: tb/tb_tlu_record_reader.sv
// Directed and randomized bench for tlu_record_reader; words come from a queue-based TLU stream, and records are scoreboarded against a rule-level model.
module tb_tlu_record_reader;
    logic        BUS_CLK = 1'b0;
    logic        RST = 1'b1, ENABLE = 1'b0, CLEAR = 1'b0, FIFO_EMPTY = 1'b1, REC_READY = 1'b0;
    logic [15:0] FIFO_DATA = 16'h0;
    logic        FIFO_READ, REC_VALID, REC_SEQ_ERR, REC_TS_ERR;
    logic [31:0] REC_TRIG_ID, REC_LE, REC_CNT;
    logic [63:0] REC_TIME_STAMP;
    logic [7:0]  SEQ_ERR_CNT, TS_ERR_CNT;

    always #5 BUS_CLK = ~BUS_CLK;

    tlu_record_reader dut (
        .BUS_CLK(BUS_CLK), .RST(RST), .ENABLE(ENABLE), .CLEAR(CLEAR),
        .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
        .REC_VALID(REC_VALID), .REC_READY(REC_READY), .REC_TRIG_ID(REC_TRIG_ID),
        .REC_TIME_STAMP(REC_TIME_STAMP), .REC_LE(REC_LE), .REC_SEQ_ERR(REC_SEQ_ERR),
        .REC_TS_ERR(REC_TS_ERR), .REC_CNT(REC_CNT), .SEQ_ERR_CNT(SEQ_ERR_CNT), .TS_ERR_CNT(TS_ERR_CNT)
    );

    typedef struct {
        logic [31:0] trig;
        logic [63:0] ts;
        logic [31:0] le;
        logic        seq;
        logic        tse;
        logic [31:0] cnt;
        logic [7:0]  sc;
        logic [7:0]  tc;
    } exp_t;

    int          checks = 0, errors = 0;
    logic [15:0] wq[$];
    exp_t        expq[$];
    bit          m_first;
    logic [31:0] m_prev_trig, m_cnt;
    logic [63:0] m_prev_ts;
    int          m_sc, m_tc;
    int          rd_total = 0, vcyc = 0, accepted = 0, run = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        m_first = 1'b1;
        m_cnt = 32'd0;
        m_sc = 0;
        m_tc = 0;
    endfunction

    // clr_xfer: the record is transferred in the same cycle as CLEAR.
    function automatic void model_rec(input logic [31:0] t, input logic [63:0] ts, input logic [31:0] le, input bit clr_xfer);
        exp_t e;
        bit   first;
        first = m_first || clr_xfer;
        e.trig = t;
        e.ts = ts;
        e.le = le;
        e.seq = !first && (t != m_prev_trig + 32'd1);
        e.tse = !first && (ts <= m_prev_ts);
        if (clr_xfer) begin
            m_cnt = 32'd0;
            m_sc = 0;
            m_tc = 0;
        end else begin
            m_cnt = m_cnt + 32'd1;
            if (e.seq && m_sc < 255) m_sc++;
            if (e.tse && m_tc < 255) m_tc++;
        end
        m_first = 1'b0;
        m_prev_trig = t;
        m_prev_ts = ts;
        e.cnt = m_cnt;
        e.sc = 8'(m_sc);
        e.tc = 8'(m_tc);
        expq.push_back(e);
    endfunction

    function automatic void drive();
        FIFO_EMPTY = (wq.size() == 0);
        FIFO_DATA = (wq.size() != 0) ? wq[0] : 16'h0;
    endfunction

    function automatic void push_words(input logic [31:0] t, input logic [63:0] ts, input logic [31:0] le);
        logic [127:0] r;
        r = {t, ts, le};
        for (int k = 0; k < 8; k++) wq.push_back(r[16*k +: 16]);
        drive();
    endfunction

    function automatic void send(input logic [31:0] t, input logic [63:0] ts, input logic [31:0] le);
        model_rec(t, ts, le, 1'b0);
        push_words(t, ts, le);
    endfunction

    task automatic step();
        logic rd;
        exp_t e;
        @(negedge BUS_CLK);
        rd = FIFO_READ;
        if (REC_VALID && REC_READY) begin
            chk("rec_expected", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("trig_id", 64'(REC_TRIG_ID), 64'(e.trig));
                chk("time_stamp", REC_TIME_STAMP, e.ts);
                chk("le", 64'(REC_LE), 64'(e.le));
                chk("seq_err", 64'(REC_SEQ_ERR), 64'(e.seq));
                chk("ts_err", 64'(REC_TS_ERR), 64'(e.tse));
                chk("rec_cnt", 64'(REC_CNT), 64'(e.cnt));
                chk("seq_err_cnt", 64'(SEQ_ERR_CNT), 64'(e.sc));
                chk("ts_err_cnt", 64'(TS_ERR_CNT), 64'(e.tc));
            end
            accepted++;
        end
        if (REC_VALID) vcyc++;
        if (rd) run++;
        else if (run != 0) begin
            chk("read_burst_len", 64'(run), 64'd8);
            run = 0;
        end
        @(posedge BUS_CLK);
        #1;
        if (rd && wq.size() != 0) begin
            void'(wq.pop_front());
            rd_total++;
        end
        drive();
    endtask

    task automatic do_reset(input int cyc);
        RST = 1'b1;
        run = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge BUS_CLK);
            chk("fifo_read_in_rst", 64'(FIFO_READ), 64'd0);
            @(posedge BUS_CLK);
            #1;
        end
        RST = 1'b0;
        wq.delete();
        expq.delete();
        model_clear();
        m_prev_trig = 32'd0;
        m_prev_ts = 64'd0;
        drive();
    endtask

    task automatic pulse_clear();
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        model_clear();
        chk("clear_rec_cnt", 64'(REC_CNT), 64'd0);
        chk("clear_seq_cnt", 64'(SEQ_ERR_CNT), 64'd0);
        chk("clear_ts_cnt", 64'(TS_ERR_CNT), 64'd0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && !(expq.size() == 0 && wq.size() == 0 && !REC_VALID); i++) step();
        chk("drain_exp_left", 64'(expq.size()), 64'd0);
        chk("drain_words_left", 64'(wq.size()), 64'd0);
    endtask

    initial begin
        int          r0, v0, a0, sent;
        logic [31:0] g_trig;
        logic [63:0] g_ts;

        do_reset(3);
        chk("rst_fifo_read", 64'(FIFO_READ), 64'd0);
        chk("rst_valid", 64'(REC_VALID), 64'd0);
        chk("rst_trig", 64'(REC_TRIG_ID), 64'd0);
        chk("rst_ts", REC_TIME_STAMP, 64'd0);
        chk("rst_le", 64'(REC_LE), 64'd0);
        chk("rst_flags", 64'({REC_SEQ_ERR, REC_TS_ERR}), 64'd0);
        chk("rst_counters", 64'({REC_CNT, SEQ_ERR_CNT, TS_ERR_CNT}), 64'd0);

        // Single record, consumer always ready.
        ENABLE = 1'b1;
        REC_READY = 1'b1;
        r0 = rd_total; v0 = vcyc; a0 = accepted;
        send(32'd5, 64'h100, 32'h04030201);
        for (int i = 0; i < 15; i++) step();
        chk("one_rec_reads", 64'(rd_total - r0), 64'd8);
        chk("one_rec_valid_cycles", 64'(vcyc - v0), 64'd1);
        chk("one_rec_accepted", 64'(accepted - a0), 64'd1);
        chk("one_rec_cnt", 64'(REC_CNT), 64'd1);

        // Trigger-ID continuity, including the 0xFFFFFFFF -> 0 wrap.
        pulse_clear();
        send(32'd7, 64'h10, $urandom);
        send(32'd8, 64'h20, $urandom);
        send(32'd10, 64'h30, $urandom);
        drain(100);
        chk("seq_cnt_after_gap", 64'(SEQ_ERR_CNT), 64'd1);
        send(32'hFFFF_FFFF, 64'h40, $urandom);
        send(32'h0, 64'h50, $urandom);
        drain(100);
        chk("seq_cnt_after_wrap", 64'(SEQ_ERR_CNT), 64'd2);

        // Repeated timestamp and counter saturation.
        pulse_clear();
        send(32'd1, 64'h200, $urandom);
        send(32'd2, 64'h200, $urandom);
        drain(100);
        chk("ts_cnt_equal_ts", 64'(TS_ERR_CNT), 64'd1);
        for (int i = 0; i < 300; i++) send(32'd3 + 32'(i), 64'h200, $urandom);
        drain(4000);
        chk("ts_cnt_saturated", 64'(TS_ERR_CNT), 64'hFF);
        chk("rec_cnt_302", 64'(REC_CNT), 64'd302);

        // Backpressure: one record in output, one pending, third not started.
        REC_READY = 1'b0;
        a0 = accepted;
        for (int i = 0; i < 3; i++) send(32'd303 + 32'(i), 64'h1000 + 64'(i), $urandom);
        for (int i = 0; i < 40; i++) step();
        chk("bp_valid", 64'(REC_VALID), 64'd1);
        chk("bp_fifo_read", 64'(FIFO_READ), 64'd0);
        chk("bp_words_left", 64'(wq.size()), 64'd8);
        chk("bp_none_accepted", 64'(accepted - a0), 64'd0);
        REC_READY = 1'b1;
        drain(100);
        chk("bp_all_accepted", 64'(accepted - a0), 64'd3);

        // ENABLE dropped during word 3.
        r0 = rd_total; a0 = accepted;
        send(32'd306, 64'h2000, $urandom);
        send(32'd307, 64'h2001, $urandom);
        for (int i = 0; i < 50 && (rd_total - r0) < 3; i++) step();
        chk("en_reach_word3", 64'(rd_total - r0), 64'd3);
        ENABLE = 1'b0;
        for (int i = 0; i < 30; i++) step();
        chk("en_reads", 64'(rd_total - r0), 64'd8);
        chk("en_accepted", 64'(accepted - a0), 64'd1);
        chk("en_words_left", 64'(wq.size()), 64'd8);
        chk("en_fifo_read", 64'(FIFO_READ), 64'd0);
        ENABLE = 1'b1;
        drain(100);

        // CLEAR coincident with transfer: the pending record becomes the first record.
        REC_READY = 1'b0;
        send(32'd100, 64'h5000, $urandom);
        push_words(32'd300, 64'h10, 32'hCAFE_0001);
        for (int i = 0; i < 30; i++) step();
        chk("clr_fifo_read", 64'(FIFO_READ), 64'd0);
        model_rec(32'd300, 64'h10, 32'hCAFE_0001, 1'b1);
        CLEAR = 1'b1;
        REC_READY = 1'b1;
        step();
        CLEAR = 1'b0;
        drain(50);
        chk("clr_xfer_rec_cnt", 64'(REC_CNT), 64'd0);

        // Reset in the middle of a record.
        r0 = rd_total;
        send(32'd50, 64'h6000, $urandom);
        send(32'd51, 64'h6001, $urandom);
        for (int i = 0; i < 50 && (rd_total - r0) < 4; i++) step();
        chk("rst_reach_word4", 64'(rd_total - r0), 64'd4);
        do_reset(2);
        chk("mid_rst_valid", 64'(REC_VALID), 64'd0);
        chk("mid_rst_counters", 64'({REC_CNT, SEQ_ERR_CNT, TS_ERR_CNT}), 64'd0);
        chk("mid_rst_fifo_read", 64'(FIFO_READ), 64'd0);
        send($urandom, {$urandom, $urandom}, $urandom);
        drain(50);
        chk("post_rst_rec_cnt", 64'(REC_CNT), 64'd1);

        // Randomized traffic with random backpressure and ENABLE.
        g_trig = 32'hFFFF_FFF0;
        g_ts = 64'h1000;
        sent = 0;
        for (int n = 0; n < 1500 && sent < 60; n++) begin
            if ($urandom_range(0, 3) == 0 && wq.size() < 32) begin
                g_trig = ($urandom_range(0, 4) == 0) ? $urandom : g_trig + 32'd1;
                g_ts = ($urandom_range(0, 4) == 0) ? {32'h0, $urandom} : g_ts + 64'($urandom_range(1, 50));
                send(g_trig, g_ts, $urandom);
                sent++;
            end
            REC_READY = ($urandom_range(0, 2) != 0);
            ENABLE = ($urandom_range(0, 5) != 0);
            step();
        end
        ENABLE = 1'b1;
        REC_READY = 1'b1;
        drain(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
